comp_arbiter: RTL

Time-shares one unsigned magnitude comparator (gr/eq/ls of two WIDTH-bit operands) among NREQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake and receives a registered three-flag result with its own valid/ready handshake. The block sits between the edge-processing units and a single shared comparator instance, so comparator area is paid once.

---
 rtl/comp_arbiter_if.sv | 26 ++
 rtl/comp_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/comp_arbiter_if.sv
// Requester-side bundle for comp_arbiter: operand pairs in, three-flag results out.
// The master modport is the requester side; the slave modport is the arbiter.
interface comp_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic                  rsp_gr;
    logic                  rsp_eq;
    logic                  rsp_ls;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_gr, rsp_eq, rsp_ls
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_gr, rsp_eq, rsp_ls
    );
endinterface

// File: rtl/comp_arbiter.sv
// Round-robin time-sharing of one unsigned magnitude comparator among NREQ
// requesters; one operation in flight, registered gr/eq/ls result per grant.
module comp_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic           clk,
    input  logic           rst,
    comp_arbiter_if.slave  bus,
    output logic           busy
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     rr_ptr, owner, grant;
    logic              grant_vld, own_rdy;
    logic [WIDTH-1:0]  op_a, op_b, cap_a, cap_b;
    logic              gr_q, eq_q, ls_q;
    logic [NREQ-1:0]   grant_sel, own_sel;
    int unsigned       idx;

    // Scan from rr_ptr upward with wrap; the first pending index wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_vld && idx == i && bus.req_valid[i]) begin
                    grant     = IW'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_sel = '0;
        own_sel   = '0;
        own_rdy   = 1'b0;
        cap_a     = '0;
        cap_b     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == IW'(i)) begin
                grant_sel[i] = grant_vld;
                cap_a        = bus.req_a[i*WIDTH +: WIDTH];
                cap_b        = bus.req_b[i*WIDTH +: WIDTH];
            end
            if (owner == IW'(i)) begin
                own_sel[i] = 1'b1;
                own_rdy    = bus.rsp_ready[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                if (!rst) bus.req_ready = grant_sel;
                if (grant_vld) state_nx = CMP;
            end
            CMP:  state_nx = RESP;
            RESP: begin
                bus.rsp_valid = own_sel;
                if (own_rdy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            owner  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            gr_q   <= 1'b0;
            eq_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_vld) begin
                    op_a  <= cap_a;
                    op_b  <= cap_b;
                    owner <= grant;
                end
                CMP: begin
                    gr_q <= (op_a > op_b);
                    eq_q <= (op_a == op_b);
                    ls_q <= (op_a < op_b);
                end
                RESP: if (own_rdy) begin
                    rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_gr = gr_q;
    assign bus.rsp_eq = eq_q;
    assign bus.rsp_ls = ls_q;
    assign busy       = (state != IDLE);
endmodule
